// File: rtl/cam_rx_align.sv
// cam_rx_align: per-lane word aligner for the camera LVDS deserialisers.
// Every lane bitslips its deserialiser until MATCH_COUNT consecutive training words are seen.
module cam_rx_align #(
  parameter int               LANES              = 5,
  parameter int               W                  = 8,
  parameter logic [W-1:0]     TRAIN_PATTERN      = 8'h3A,
  parameter logic [W-1:0]     SYNC_TRAIN_PATTERN = 8'h3A,
  parameter logic [LANES-1:0] INVERT_MASK        = {LANES{1'b0}},
  parameter int               SLIP_WAIT          = 4,
  parameter int               MATCH_COUNT        = 16,
  parameter int               MAX_SLIPS          = 16
) (
  input  logic                 c,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LANES*W-1:0]   rxd,
  output logic [LANES-1:0]     bitslip,
  output logic [LANES*W-1:0]   rxd_out,
  output logic [LANES-1:0]     locked,
  output logic [LANES-1:0]     failed,
  output logic                 all_locked,
  output logic                 busy,
  output logic [LANES*8-1:0]   slip_count
);

  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int AW = $clog2(MAX_SLIPS + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SLIP   = 3'd2,
    WAIT   = 3'd3,
    LOCKED = 3'd4,
    FAIL   = 3'd5
  } state_t;

  state_t          state_r   [LANES];
  state_t          state_s   [LANES];
  logic [MW-1:0]   match_r   [LANES];
  logic [MW-1:0]   match_s   [LANES];
  logic [AW-1:0]   attempt_r [LANES];
  logic [AW-1:0]   attempt_s [LANES];
  logic [WW-1:0]   wait_r    [LANES];
  logic [WW-1:0]   wait_s    [LANES];
  logic [7:0]      slips_r   [LANES];
  logic [7:0]      slips_s   [LANES];

  logic [LANES*W-1:0] data_r;
  logic [LANES-1:0]   bitslip_r, locked_r, failed_r, training_r;
  logic [LANES-1:0]   bitslip_s, locked_s, failed_s, training_s;

  function automatic logic [W-1:0] lane_pattern(input int lane);
    if (lane == LANES - 1) return SYNC_TRAIN_PATTERN;
    else return TRAIN_PATTERN;
  endfunction

  // Polarity-corrected word register; runs regardless of training state.
  always_ff @(posedge c or negedge rst) begin
    if (!rst) begin
      data_r <= {(LANES*W){1'b0}};
    end else begin
      for (int i = 0; i < LANES; i++) begin
        data_r[i*W +: W] <= rxd[i*W +: W] ^ {W{INVERT_MASK[i]}};
      end
    end
  end

  // Per-lane training FSM next state, counters and registered-output next values.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      state_s[i]   = state_r[i];
      match_s[i]   = match_r[i];
      attempt_s[i] = attempt_r[i];
      wait_s[i]    = wait_r[i];
      slips_s[i]   = slips_r[i];
      if (start) begin
        // Restart wins over every state; a pending bitslip is not re-issued.
        state_s[i]   = CHECK;
        match_s[i]   = {MW{1'b0}};
        attempt_s[i] = {AW{1'b0}};
        wait_s[i]    = {WW{1'b0}};
        slips_s[i]   = 8'd0;
      end else begin
        case (state_r[i])
          IDLE: state_s[i] = IDLE;
          CHECK: begin
            if (data_r[i*W +: W] == lane_pattern(i)) begin
              match_s[i] = match_r[i] + MW'(1);
              if (match_r[i] == MW'(MATCH_COUNT - 1)) state_s[i] = LOCKED;
              else state_s[i] = CHECK;
            end else begin
              match_s[i] = {MW{1'b0}};
              if (attempt_r[i] == AW'(MAX_SLIPS)) state_s[i] = FAIL;
              else state_s[i] = SLIP;
            end
          end
          SLIP: begin
            attempt_s[i] = attempt_r[i] + AW'(1);
            if (slips_r[i] != 8'hFF) slips_s[i] = slips_r[i] + 8'd1;
            else slips_s[i] = slips_r[i];
            wait_s[i]  = {WW{1'b0}};
            state_s[i] = WAIT;
          end
          WAIT: begin
            if (wait_r[i] == WW'(SLIP_WAIT - 1)) begin
              wait_s[i]  = {WW{1'b0}};
              state_s[i] = CHECK;
            end else begin
              wait_s[i]  = wait_r[i] + WW'(1);
              state_s[i] = WAIT;
            end
          end
          LOCKED:  state_s[i] = LOCKED;
          FAIL:    state_s[i] = FAIL;
          default: state_s[i] = IDLE;
        endcase
      end
      bitslip_s[i]  = (state_s[i] == SLIP);
      locked_s[i]   = (state_s[i] == LOCKED);
      failed_s[i]   = (state_s[i] == FAIL);
      training_s[i] = (state_s[i] == CHECK) || (state_s[i] == SLIP) || (state_s[i] == WAIT);
    end
  end

  // Per-lane state, counters and flag registers.
  always_ff @(posedge c or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        state_r[i]   <= IDLE;
        match_r[i]   <= {MW{1'b0}};
        attempt_r[i] <= {AW{1'b0}};
        wait_r[i]    <= {WW{1'b0}};
        slips_r[i]   <= 8'd0;
      end
      bitslip_r  <= {LANES{1'b0}};
      locked_r   <= {LANES{1'b0}};
      failed_r   <= {LANES{1'b0}};
      training_r <= {LANES{1'b0}};
    end else begin
      for (int i = 0; i < LANES; i++) begin
        state_r[i]   <= state_s[i];
        match_r[i]   <= match_s[i];
        attempt_r[i] <= attempt_s[i];
        wait_r[i]    <= wait_s[i];
        slips_r[i]   <= slips_s[i];
      end
      bitslip_r  <= bitslip_s;
      locked_r   <= locked_s;
      failed_r   <= failed_s;
      training_r <= training_s;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_slip_count
    assign slip_count[g*8 +: 8] = slips_r[g];
  end

  assign rxd_out    = data_r;
  assign bitslip    = bitslip_r;
  assign locked     = locked_r;
  assign failed     = failed_r;
  assign all_locked = &locked_r;
  assign busy       = |training_r;

endmodule

// File: tb/tb_cam_rx_align.sv
// Directed bench for cam_rx_align: a bitslip-aware deserialiser model drives the lanes,
// a latency-1 scoreboard checks the corrected data path, and training results are checked per step.
module tb_cam_rx_align;
  localparam int               LANES = 5;
  localparam int               W     = 8;
  localparam int               RW    = LANES * W;
  localparam logic [LANES-1:0] MASK  = 5'b00010;
  localparam logic [7:0]       PAT   = 8'h3A;

  logic               c = 1'b0;
  logic               rst;
  logic               start;
  logic [RW-1:0]      rxd;
  logic [RW-1:0]      rxd_out;
  logic [LANES-1:0]   bitslip, locked, failed;
  logic               all_locked, busy;
  logic [LANES*8-1:0] slip_count;

  int               n_vec = 0;
  int               n_err = 0;
  int               cyc   = 0;
  int               rot       [LANES];
  bit               zero      [LANES];
  int               last_slip [LANES];
  logic [LANES-1:0] prev_bs;
  logic [RW-1:0]    word_model;
  logic [RW-1:0]    sb_q [$];

  always #5 c = ~c;

  cam_rx_align #(
    .LANES(LANES), .W(W), .TRAIN_PATTERN(PAT), .SYNC_TRAIN_PATTERN(PAT),
    .INVERT_MASK(MASK), .SLIP_WAIT(4), .MATCH_COUNT(16), .MAX_SLIPS(16)
  ) dut (
    .c(c), .rst(rst), .start(start), .rxd(rxd), .bitslip(bitslip),
    .rxd_out(rxd_out), .locked(locked), .failed(failed),
    .all_locked(all_locked), .busy(busy), .slip_count(slip_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] x, input int r);
    logic [15:0] t;
    t = {x, x} << r;
    return t[15:8];
  endfunction

  // Deserialiser model: each lane shows the training word rotated by its remaining offset.
  task automatic drive();
    for (int i = 0; i < LANES; i++) begin
      word_model[i*W +: W] = zero[i] ? 8'h00 : rotl(PAT, rot[i]);
      rxd[i*W +: W] = word_model[i*W +: W] ^ {W{MASK[i]}};
    end
  endtask

  task automatic step();
    logic [RW-1:0] exp_w;
    logic          start_seen;
    sb_q.push_back(rst ? word_model : {RW{1'b0}});
    start_seen = start;
    @(posedge c);
    #1;
    cyc++;
    exp_w = sb_q.pop_front();
    check("rxd_out", rxd_out, exp_w);
    if (start_seen) begin
      for (int i = 0; i < LANES; i++) last_slip[i] = -1;
    end
    for (int i = 0; i < LANES; i++) begin
      if (bitslip[i]) begin
        check("bitslip_back_to_back", prev_bs[i], 1'b0);
        if (last_slip[i] >= 0) check("bitslip_gap", cyc - last_slip[i], 6);
        last_slip[i] = cyc;
        rot[i] = (rot[i] + 7) % 8;
      end
    end
    prev_bs = bitslip;
    drive();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_lock(input int budget);
    int n;
    n = 0;
    while (!all_locked && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    prev_bs = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      rot[i] = 0;
      zero[i] = 1'b0;
      last_slip[i] = -1;
    end
    drive();
    #2 rst = 1'b0;

    // Reset with random input: every output held at zero.
    for (int k = 0; k < 4; k++) begin
      rxd = RW'({$urandom(), $urandom()});
      step();
      check("reset_outputs", {bitslip, locked, failed, all_locked, busy, slip_count}, 64'd0);
    end
    rst = 1'b1;

    // Released without start: lanes stay idle.
    for (int k = 0; k < 5; k++) begin
      step();
      check("idle_no_start", {bitslip, locked, failed, busy}, 64'd0);
    end

    // Aligned input: lock exactly 16 edges after the start edge, no slips.
    pulse_start();
    for (int k = 1; k <= 16; k++) begin
      step();
      check("aligned_bitslip", bitslip, 5'd0);
      if (k < 16) check("aligned_lock_early", {locked, busy}, {5'h00, 1'b1});
      else check("aligned_lock_16", {all_locked, locked, busy}, {1'b1, 5'h1F, 1'b0});
    end
    check("aligned_slips", slip_count, 40'd0);
    check("inverted_lane1", rxd_out[15:8], 8'h3A);

    // Misaligned offsets: slip count per lane equals its offset.
    rot = '{0, 1, 3, 5, 7};
    drive();
    step();
    pulse_start();
    wait_lock(400);
    check("mis_all_locked", {all_locked, locked}, {1'b1, 5'h1F});
    check("mis_slip_count", slip_count, {8'd7, 8'd5, 8'd3, 8'd1, 8'd0});

    // Lane 2 stuck at zero: fails after 16 slips, others lock.
    zero[2] = 1'b1;
    drive();
    pulse_start();
    wait_idle(400);
    check("fail_flags", {failed, locked, all_locked, busy}, {5'b00100, 5'b11011, 1'b0, 1'b0});
    check("fail_slips", slip_count[23:16], 8'd16);
    for (int k = 0; k < 20; k++) begin
      step();
      check("fail_no_slip", bitslip[2], 1'b0);
    end

    // Recover lane 2, then restart with lane 0 corrupted.
    zero[2] = 1'b0;
    rot[2] = 0;
    drive();
    pulse_start();
    wait_lock(100);
    check("relock", {all_locked, failed}, {1'b1, 5'h00});
    rot[0] = 3;
    drive();
    pulse_start();
    check("restart_drop", {locked, all_locked}, 64'd0);
    wait_lock(200);
    check("restart_relock", all_locked, 1'b1);
    check("restart_slips", slip_count[7:0], 8'd3);

    // Start while lane 0 is in WAIT: counters clear, no double slip.
    rot[0] = 2;
    drive();
    pulse_start();
    for (int n = 0; n < 50 && !bitslip[0]; n++) step();
    check("wait_slip_seen", bitslip[0], 1'b1);
    step();
    check("wait_count_before", slip_count[7:0], 8'd1);
    pulse_start();
    check("wait_restart_clear", {slip_count[7:0], bitslip[0], locked[0]}, 64'd0);
    wait_lock(200);
    check("wait_restart_lock", all_locked, 1'b1);
    check("wait_restart_slips", slip_count[7:0], 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
